// File: rtl/cdc_sync.sv
// Multi-stage synchronizer for a WIDTH-bit signal from a foreign clock domain,
// with level, Gray-pointer (binary conversion + multi-bit checker) and toggle-to-pulse modes.
module cdc_sync #(
  parameter int unsigned      WIDTH   = 4,
  parameter int unsigned      STAGES  = 2,
  parameter int unsigned      MODE    = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_bin,
  output logic             chg,
  output logic [WIDTH-1:0] pulse,
  output logic             err
);

  if (STAGES < 2 || STAGES > 4 || WIDTH < 1 || WIDTH > 32 || MODE > 2) begin : g_bad_param
    $error("cdc_sync: parameter out of range");
  end

  logic [STAGES-1:0][WIDTH-1:0] s;
  logic [WIDTH-1:0]             h;
  logic [WIDTH-1:0]             diff;

  // Plain flop chain: nothing between stages so metastability has a full cycle to resolve.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s <= {STAGES{RST_VAL}};
      h <= RST_VAL;
    end else begin
      s <= {s[STAGES-2:0], in};
      h <= s[STAGES-1];
    end
  end

  assign out   = s[STAGES-1];
  assign diff  = out ^ h;
  assign chg   = |diff;
  assign pulse = (MODE == 2) ? diff : '0;

  if (MODE == 1) begin : g_gray
    logic [WIDTH-1:0] bin_g;
    logic             viol;

    // Binary bit i is the XOR of all Gray bits from i up to the MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bin_g[i] = ^(out >> i);
    end
    assign out_bin = bin_g;
    assign viol    = $countones(diff) > 1;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)         err <= 1'b0;
      else if (viol)    err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end else begin : g_plain
    logic unused_clr;
    assign unused_clr = err_clr;
    assign out_bin    = out;
    assign err        = 1'b0;
  end

endmodule

// File: tb/tb_cdc_sync.sv
// Scoreboard bench for cdc_sync: level instances at STAGES 2/3/4, one Gray and one toggle instance.
module tb_cdc_sync;

  typedef struct {
    logic [3:0] val;
    logic [3:0] bin;
    logic [3:0] pls;
    int         cyc;
  } exp_t;

  localparam int STG [5] = '{2, 3, 4, 2, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] lin [3];
  logic [3:0] lout [3];
  logic [3:0] lbin [3];
  logic [3:0] lpls [3];
  logic       lchg [3];
  logic       lerr [3];
  logic [3:0] gin, gout, gbin, gpls;
  logic       gchg, gerr;
  logic [1:0] tin, tout, tbin, tpls;
  logic       tchg, terr;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  exp_t       q [5][$];
  logic [3:0] prev [5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_lvl
    cdc_sync #(.WIDTH(4), .STAGES(g + 2), .MODE(0), .RST_VAL(4'hA)) u_lvl (
      .clk(clk), .rst(rst), .in(lin[g]), .err_clr(err_clr), .out(lout[g]),
      .out_bin(lbin[g]), .chg(lchg[g]), .pulse(lpls[g]), .err(lerr[g]));
  end

  cdc_sync #(.WIDTH(4), .STAGES(2), .MODE(1), .RST_VAL(4'h0)) u_gray (
    .clk(clk), .rst(rst), .in(gin), .err_clr(err_clr), .out(gout),
    .out_bin(gbin), .chg(gchg), .pulse(gpls), .err(gerr));

  cdc_sync #(.WIDTH(2), .STAGES(2), .MODE(2), .RST_VAL(2'b00)) u_tog (
    .clk(clk), .rst(rst), .in(tin), .err_clr(err_clr), .out(tout),
    .out_bin(tbin), .chg(tchg), .pulse(tpls), .err(terr));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] rstv(input int ch);
    return (ch < 3) ? 4'hA : 4'h0;
  endfunction

  task automatic push_exp(input int ch, input logic [3:0] v, input logic [3:0] b);
    exp_t e;
    e.val = v;
    e.bin = b;
    e.pls = (ch == 4) ? (v ^ prev[ch]) : 4'h0;
    e.cyc = cyc + STG[ch];
    q[ch].push_back(e);
    prev[ch] = v;
  endtask

  // Drive a channel input; push an expectation unless the value is meant to be lost.
  task automatic drive(input int ch, input logic [3:0] v, input logic [3:0] b, input bit push);
    if (ch < 3)       lin[ch] = v;
    else if (ch == 3) gin = v;
    else              tin = v[1:0];
    if (push) push_exp(ch, v, b);
  endtask

  task automatic flush_all();
    for (int c = 0; c < 5; c++) begin
      q[c].delete();
      prev[c] = rstv(c);
    end
  endtask

  // Monitor: every chg cycle pops one expectation and compares value, binary, pulse and arrival cycle.
  always @(negedge clk) begin : mon
    logic       c_chg;
    logic [3:0] o, b, p;
    exp_t       e;
    for (int c = 0; c < 5; c++) begin
      if (c < 3)       begin c_chg = lchg[c]; o = lout[c]; b = lbin[c]; p = lpls[c]; end
      else if (c == 3) begin c_chg = gchg; o = gout; b = gbin; p = gpls; end
      else             begin c_chg = tchg; o = {2'b00, tout}; b = {2'b00, tbin}; p = {2'b00, tpls}; end
      if (c_chg) begin
        total++;
        if (q[c].size() == 0) begin
          bad++;
          $display("FAIL unexpected_chg ch%0d: out=%h at cyc %0d, no change expected", c, o, cyc);
        end else begin
          e = q[c].pop_front();
          if (o !== e.val || b !== e.bin || p !== e.pls || cyc != e.cyc) begin
            bad++;
            $display("FAIL chg_ch%0d: got out=%h bin=%h pulse=%h cyc=%0d want out=%h bin=%h pulse=%h cyc=%0d",
                     c, o, b, p, cyc, e.val, e.bin, e.pls, e.cyc);
          end
        end
      end else if (p !== 4'h0) begin
        total++;
        bad++;
        $display("FAIL stray_pulse ch%0d: got %h want 0 at cyc %0d", c, p, cyc);
      end
      if (q[c].size() > 0 && q[c][0].cyc <= cyc) begin
        e = q[c].pop_front();
        total++;
        bad++;
        $display("FAIL missed_chg ch%0d: got out=%h want out=%h by cyc %0d", c, o, e.val, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] gv;
    int         c0;
    for (int c = 0; c < 3; c++) lin[c] = 4'hA;
    gin = 4'h0;
    tin = 2'b00;
    flush_all();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out", lout[0], 4'hA);
    chk("rst_chg", lchg[0], 0);
    chk("rst_gout", gout, 4'h0);
    chk("rst_gerr", gerr, 0);
    chk("rst_tpls", tpls, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Latency sweep on STAGES 2/3/4: A->0 then 0->9
    for (int c = 0; c < 3; c++) drive(c, 4'h0, 4'h0, 1);
    repeat (8) @(negedge clk);
    for (int c = 0; c < 3; c++) drive(c, 4'h9, 4'h9, 1);
    repeat (8) @(negedge clk);

    // Back-to-back changes must give consecutive chg cycles
    drive(0, 4'h3, 4'h3, 1);
    @(negedge clk); drive(0, 4'hC, 4'hC, 1);
    @(negedge clk); drive(0, 4'h1, 4'h1, 1);
    repeat (6) @(negedge clk);

    // Reset mid-stream: 5 is in flight and must be discarded
    drive(0, 4'h5, 4'h5, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    flush_all();
    #1;
    chk("mid_rst_out", lout[0], 4'hA);
    chk("mid_rst_chg", lchg[0], 0);
    chk("mid_rst_out_s4", lout[2], 4'hA);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push_exp(0, 4'h5, 4'h5);
    push_exp(1, 4'h9, 4'h9);
    push_exp(2, 4'h9, 4'h9);
    repeat (8) @(negedge clk);

    // Async reset between edges, then no chg while in == RST_VAL
    drive(1, 4'hA, 4'hA, 1);
    drive(2, 4'hA, 4'hA, 1);
    repeat (8) @(negedge clk);
    drive(0, 4'hA, 4'hA, 0);
    @(posedge clk); #2;
    chk("pre_async_out", lout[0], 4'h5);
    rst = 1'b0;
    flush_all();
    #1;
    chk("async_rst_out", lout[0], 4'hA);
    chk("async_rst_chg", lchg[0], 0);
    rst = 1'b1;
    repeat (8) @(negedge clk);

    // Gray count 1..15 then wrap to 0, each held 4 cycles
    for (int i = 1; i < 16; i++) begin
      gv = 4'(i ^ (i >> 1));
      drive(3, gv, 4'(i), 1);
      repeat (4) @(negedge clk);
    end
    drive(3, 4'b0000, 4'h0, 1);
    repeat (4) @(negedge clk);
    chk("gray_count_err", gerr, 0);

    // Gray violation, sticky err, clear, set-wins
    drive(3, 4'b0011, 4'b0010, 1);
    repeat (2) @(negedge clk);
    chk("viol_err_pre", gerr, 0);
    @(negedge clk);
    chk("viol_err_set", gerr, 1);
    repeat (3) @(negedge clk);
    chk("viol_err_sticky", gerr, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", gerr, 0);
    drive(3, 4'b0000, 4'b0000, 1);
    c0 = cyc;
    repeat (2) @(negedge clk);
    chk("set_wins_pre", gerr, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("set_wins", gerr, 1);
    chk("set_wins_cyc", cyc, c0 + 3);
    repeat (2) @(negedge clk);
    chk("set_wins_hold", gerr, 1);

    // Toggle mode: bit0, bit1 ten cycles later, then both
    drive(4, 4'b01, 4'b01, 1);
    repeat (10) @(negedge clk);
    drive(4, 4'b11, 4'b11, 1);
    repeat (10) @(negedge clk);
    drive(4, 4'b00, 4'b00, 1);
    repeat (8) @(negedge clk);
    chk("tog_err", terr, 0);

    for (int c = 0; c < 5; c++) chk($sformatf("drain_ch%0d", c), q[c].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
